// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    // Minimum binary width that holds the largest NDIGITS-digit decimal value.
    function automatic int unsigned bcd_bin_width(input int unsigned ndigits);
        longint unsigned max_val;
        int unsigned     w;
        max_val = 64'd1;
        w       = 0;
        for (int unsigned i = 0; i < ndigits; i++) begin
            max_val = max_val * 64'd10;
        end
        max_val = max_val - 64'd1;
        while (max_val != 64'd0) begin
            max_val = max_val >> 1;
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// One accumulate step of the converter: result = acc*10 + digit.
module bcd_mac_step
    import bcd_pkg::*;
#(
    parameter int unsigned W = 18
) (
    input  logic [W-1:0]       acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [W-1:0]       result_c
);

    // Multiply by ten as shift-and-add, then add the incoming digit.
    assign result_c = (acc << 3) + (acc << 1) + W'(digit);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, MSD first, one digit per clock.
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned BIN_W   = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DIGIT_W*NDIGITS-1:0] bcd_in,
    output logic                       busy,
    output logic                       done,
    output logic [BIN_W-1:0]           bin_out,
    output logic                       err
);

    localparam int unsigned IN_W  = DIGIT_W * NDIGITS;
    localparam int unsigned ACC_W = BIN_W + DIGIT_W;
    localparam int unsigned CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    // Reject configurations whose result width cannot hold every decimal value.
    generate
        if (BIN_W < bcd_bin_width(NDIGITS)) begin : g_bin_w_check
            $error("bcd_to_bin_seq: BIN_W too small for NDIGITS");
        end
    endgenerate

    state_t               state;
    logic [IN_W-1:0]      shreg;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_next_c;
    logic [CNT_W-1:0]     cnt;
    logic [DIGIT_W-1:0]   top_digit_c;

    assign top_digit_c = shreg[IN_W-1 -: DIGIT_W];

    bcd_mac_step #(
        .W (ACC_W)
    ) u_mac (
        .acc      (acc),
        .digit    (top_digit_c),
        .result_c (acc_next_c)
    );

`ifdef BCD_DIGIT_CHECK_EN
    logic bad_flag;
`endif

    // Control FSM and datapath registers; busy tracks the state one cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            shreg   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            bad_flag <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= bcd_in;
                        acc   <= '0;
                        cnt   <= CNT_W'(NDIGITS - 1);
`ifdef BCD_DIGIT_CHECK_EN
                        bad_flag <= 1'b0;
`endif
                        state <= CONV;
                    end
                end
                CONV: begin
                    acc   <= acc_next_c;
                    shreg <= shreg << DIGIT_W;
                    cnt   <= cnt - CNT_W'(1);
`ifdef BCD_DIGIT_CHECK_EN
                    if (top_digit_c > 4'd9) begin
                        bad_flag <= 1'b1;
                    end
`endif
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                    err     <= bad_flag;
                    bin_out <= bad_flag ? '0 : acc[BIN_W-1:0];
`else
                    err     <= 1'b0;
                    bin_out <= acc[BIN_W-1:0];
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed and random checks of bcd_to_bin_seq against a decimal reference model.
module tb_bcd_to_bin_seq;

    localparam int unsigned NDIGITS = 4;
    localparam int unsigned BIN_W   = 14;
    localparam int unsigned LAT     = NDIGITS + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [15:0]       bcd_in;
    logic              busy;
    logic              done;
    logic [BIN_W-1:0]  bin_out;
    logic              err;

    int n_checks;
    int n_errors;

    bcd_to_bin_seq #(
        .NDIGITS (NDIGITS),
        .BIN_W   (BIN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: weighted sum of nibbles in plain decimal arithmetic.
    task automatic ref_conv(input logic [15:0] bcd, output logic [31:0] exp_bin,
                            output logic [31:0] exp_err);
        int  total;
        int  weight;
        int  d;
        bit  bad;
        total  = 0;
        weight = 1;
        bad    = 1'b0;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            d = int'((bcd >> (4 * i)) & 16'h000F);
            if (d > 9) bad = 1'b1;
            total  = total + d * weight;
            weight = weight * 10;
        end
`ifdef BCD_DIGIT_CHECK_EN
        exp_err = bad ? 32'd1 : 32'd0;
        exp_bin = bad ? 32'd0 : 32'(total % (1 << BIN_W));
`else
        exp_err = 32'd0;
        exp_bin = 32'(total % (1 << BIN_W));
`endif
    endtask

    // Single conversion with latency, busy window, result and one-cycle done checks.
    task automatic do_conv(input logic [15:0] bcd, input string tag);
        logic [31:0] eb;
        logic [31:0] ee;
        int          lat;
        int          nbusy;
        ref_conv(bcd, eb, ee);
        bcd_in = bcd;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 0;
        nbusy  = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'(LAT));
        check({tag, "_bin"}, 32'(bin_out), eb);
        check({tag, "_err"}, 32'(err), ee);
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_clear"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] eb;
        logic [31:0] ee;
        logic [15:0] rnd;
        int          t1;
        int          t2;
        int          ndone;
        logic [31:0] bin_seen;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start    = 1'b0;
        bcd_in   = 16'h0000;

        // Reset held two cycles.
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bin", 32'(bin_out), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_done", 32'(done), 32'd0);

        // Basic conversion.
        do_conv(16'h1234, "c1234");
        check("c1234_const", 32'(bin_out), 32'd1234);

        // Back-to-back with start held; input changes after capture are ignored.
        bcd_in = 16'h9999;
        start  = 1'b1;
        tick();
        bcd_in = 16'h0000;
        t1 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                t1 = k;
                break;
            end
        end
        check("b2b_first_latency", 32'(t1), 32'(LAT));
        check("b2b_first_bin", 32'(bin_out), 32'd9999);
        tick();
        start = 1'b0;
        t2 = 0;
        for (int k = 2; k <= 21; k++) begin
            tick();
            if (done) begin
                t2 = k;
                break;
            end
        end
        check("b2b_spacing", 32'(t2), 32'(NDIGITS + 2));
        check("b2b_second_bin", 32'(bin_out), 32'd0);
        tick();
        check("b2b_no_third", 32'(done), 32'd0);

        // Start while busy is ignored.
        bcd_in = 16'h0042;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        start  = 1'b1;
        bcd_in = 16'h7777;
        tick();
        start  = 1'b0;
        ndone    = 0;
        bin_seen = 32'hFFFF_FFFF;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (done) begin
                ndone++;
                bin_seen = 32'(bin_out);
            end
        end
        check("ignore_done_count", 32'(ndone), 32'd1);
        check("ignore_bin", bin_seen, 32'd42);

        // Reset during the third conversion cycle aborts the conversion.
        bcd_in = 16'h5678;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_bin", 32'(bin_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_bin_held", 32'(bin_out), 32'd0);
        do_conv(16'h0001, "c0001");
        check("c0001_const", 32'(bin_out), 32'd1);

        // Invalid digit handling.
        do_conv(16'h12A4, "c12A4");
`ifdef BCD_DIGIT_CHECK_EN
        check("c12A4_const_bin", 32'(bin_out), 32'd0);
        check("c12A4_const_err", 32'(err), 32'd1);
`else
        check("c12A4_const_bin", 32'(bin_out), 32'd1304);
        check("c12A4_const_err", 32'(err), 32'd0);
`endif

        // Random conversions, mostly valid digits with occasional raw nibbles.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < int'(NDIGITS); i++) begin
                if ($urandom_range(0, 7) == 0)
                    rnd[4*i +: 4] = 4'($urandom_range(0, 15));
                else
                    rnd[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            do_conv(rnd, "rand");
        end

        // Extremes.
        do_conv(16'h0000, "c0000");
        do_conv(16'hFFFF, "cFFFF");
        ref_conv(16'h9999, eb, ee);
        check("model_9999", eb, 32'd9999);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
